prefix_subtractor_pipe: RTL and testbench
=========================================

// Module: prefix_subtractor_pipe
// PURPOSE
//  Pipelined WIDTH-bit subtractor: diff = a - b - b_in, with borrow_out; Kogge-Stone prefix borrow network.
//  Companion to the prefix adder (other direction: a + ~b + ~b_in on the same prefix structure).
//  Two register stages with valid/ready handshakes on both sides; sustains one operation per clock.
//  Sits between an operand producer and a result consumer that may apply backpressure.
// PARAMETERS
//  WIDTH  16  operand/result width; power of two, 4..64
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      a/b/b_in valid this cycle
//  in_ready   out  1      block accepts operands this cycle
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  b_in       in   1      borrow in
//  out_valid  out  1      diff/b_out valid
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  (a - b - b_in) mod 2^WIDTH
//  b_out      out  1      1 when a < b + b_in (unsigned)
//  flags      out  3      {n,z,v}; present only with PREFIX_SUB_FLAGS_EN
// BEHAVIOUR
//  Reset (rst_n=0, async): s1_valid=s2_valid=0; out_valid=0; diff=0; b_out=0; flags=0.
//  Accept on in_valid&&in_ready; emit on out_valid&&out_ready.
//  Stage 1 registers: g_i=a_i&~b_i, p_i=a_i^~b_i, cin=~b_in, group (G,P) after the first log2(WIDTH)/2 prefix levels (rounded down), p.
//  Stage 2 registers: remaining prefix levels, diff_i = p_i ^ C_{i-1}, b_out = ~C_{WIDTH-1}.
//  Latency: accepted at edge k -> out_valid at edge k+2 (out_ready held high).
//  Advance: s2_en = !s2_valid || out_ready; s1_en = !s1_valid || s2_en.
//  in_ready = s1_en (combinational from out_ready; no skid buffer).
//  Stall: out_valid=1 && out_ready=0 -> diff/b_out/flags held stable; s1 held if full.
//  Bubbles: s2_valid <= s1_valid on s2_en; a bubble never blocks a valid entry behind it.
//  Simultaneous accept+emit with pipe full: throughput 1/cycle, no loss or duplication.
//  Wrap-around: result modulo 2^WIDTH; 0 - 1 -> all ones with b_out=1.
//  Operand fields ignored when in_valid=0; payload regs are written only when valid enters a stage.
//  Reset mid-operation: in-flight entries discarded, no partial result emitted.
//  out_valid must not drop without out_ready (bench asserts).
// CONFIGURATION
//  PREFIX_SUB_FLAGS_EN defined: flags port exists, registered in stage 2, same timing as diff:
//    n=diff[WIDTH-1]; z=(diff==0); v=(a[W-1]^b[W-1])&(diff[W-1]^a[W-1]) (signed overflow).
//    a[W-1], b[W-1] are carried through stage 1 to compute v.
//  Undefined: flags port and its registers absent; other behaviour identical.
// STRUCTURE
//  Package prefix_pkg: typedef struct packed {logic g; logic p;} pg_t; LOG2W function; flag bit index localparams.
//  Sub-module prefix_cell: black cell (G=Gh|Ph&Gl, P=Ph&Pl); gray-cell variant via parameter GRAY=1 (G only).
//  Top: generate loops for prefix levels, split by stage; two valid flags plus payload registers.
// TESTING
//  1 a=0x1234 b=0x0234 b_in=0 -> diff=0x1000 b_out=0 after exactly 2 clk.
//  2 a=0x0000 b=0x0001 b_in=0 -> diff=0xFFFF b_out=1; flags n=1 z=0 v=0.
//  3 a=0x8000 b=0x0001 b_in=0 -> diff=0x7FFF b_out=0, v=1; a=0x5555 b=0x5554 b_in=1 -> diff=0 z=1.
//  4 out_ready=0 for 5 cycles with 3 ops offered -> in_ready=0 once 2 held; results held stable;
//    release -> results in order, none lost/duplicated.
//  5 rst_n low mid-stream with 2 ops in flight -> out_valid=0 immediately (async); no stale output after release.
//  6 1000 random ops, random in_valid/out_ready -> every result equals {~b_out,diff}==({1'b1,a}-b-b_in) in order.

Source files
------------

// File: rtl/prefix_pkg.sv
// Shared types and helpers for the prefix subtractor pipeline.
// The flag bit indices are used only when PREFIX_SUB_FLAGS_EN is defined.
package prefix_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    // Ceiling log2 for elaboration-time sizing of the prefix tree.
    function automatic int LOG2W(input int w);
        int r;
        r = 0;
        for (int k = 0; k < 8; k++) begin
            if ((32'sd1 << k) < w) begin
                r = k + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prefix_cell.sv
// Kogge-Stone prefix operator. GRAY=1 builds the generate-only cell; its P output is tied low
// because the combined span already reaches bit 0 and no later cell reads it.
module prefix_cell
    import prefix_pkg::*;
#(
    parameter bit GRAY = 1'b0
) (
    input  pg_t hi,
    input  pg_t lo,
    output pg_t o
);

    assign o.g = hi.g | (hi.p & lo.g);
    assign o.p = GRAY ? 1'b0 : (hi.p & lo.p);

endmodule

// File: rtl/prefix_subtractor_pipe.sv
// Two-stage pipelined Kogge-Stone subtractor: diff = a - b - b_in, with a valid/ready handshake on both sides.
// Defining PREFIX_SUB_FLAGS_EN adds the registered {n,z,v} flags output.
module prefix_subtractor_pipe
    import prefix_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
`ifdef PREFIX_SUB_FLAGS_EN
    ,
    output logic [2:0]       flags
`endif
);

    localparam int LW  = LOG2W(WIDTH);
    localparam int S1L = LW / 2;
    localparam int S2L = LW - S1L;

    logic             s1_valid_r;
    logic             s2_valid_r;
    logic             s1_en_s;
    logic             s2_en_s;
    logic             accept_s;

    pg_t [WIDTH-1:0]  base_s;
    pg_t [WIDTH-1:0]  s1_pg_s;
    pg_t [WIDTH-1:0]  s1_pg_r;
    logic [WIDTH-1:0] s1_p_r;
    logic             s1_cin_r;

    logic [WIDTH-1:0] carry_s;
    logic [WIDTH-1:0] final_p_unused_s;
    logic [WIDTH-1:0] diff_s;
    logic             b_out_s;
    logic [WIDTH-1:0] diff_r;
    logic             b_out_r;

    assign s2_en_s  = !s2_valid_r || out_ready;
    assign s1_en_s  = !s1_valid_r || s2_en_s;
    assign in_ready = s1_en_s;
    assign accept_s = in_valid && s1_en_s;

    // Bitwise generate/propagate of a + ~b, with the carry-in ~b_in folded into bit 0.
    always_comb begin
        base_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            base_s[i].g = a[i] & ~b[i];
            base_s[i].p = a[i] ^ ~b[i];
        end
        base_s[0].g = (a[0] & ~b[0]) | ((a[0] ^ ~b[0]) & ~b_in);
    end

    for (genvar l = 0; l < S1L; l++) begin : g_s1
        pg_t [WIDTH-1:0] cur_s;
        pg_t [WIDTH-1:0] nxt_s;
        if (l == 0) begin : g_first
            assign cur_s = base_s;
        end else begin : g_rest
            assign cur_s = g_s1[l-1].nxt_s;
        end
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i < (1 << l)) begin : g_pass
                assign nxt_s[i] = cur_s[i];
            end else begin : g_cell
                prefix_cell #(.GRAY((i < (2 << l)) ? 1'b1 : 1'b0)) u_cell (
                    .hi (cur_s[i]),
                    .lo (cur_s[i - (1 << l)]),
                    .o  (nxt_s[i])
                );
            end
        end
    end

    assign s1_pg_s = g_s1[S1L-1].nxt_s;

    // Stage 1 valid flag: advances whenever stage 1 can move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
        end else if (s1_en_s) begin
            s1_valid_r <= in_valid;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 1 payload: written only when a valid operand is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_pg_r  <= '0;
            s1_p_r   <= '0;
            s1_cin_r <= 1'b0;
        end else if (accept_s) begin
            s1_pg_r  <= s1_pg_s;
            s1_p_r   <= a ^ ~b;
            s1_cin_r <= ~b_in;
        end else begin
            s1_pg_r  <= s1_pg_r;
            s1_p_r   <= s1_p_r;
            s1_cin_r <= s1_cin_r;
        end
    end

    for (genvar l = 0; l < S2L; l++) begin : g_s2
        localparam int LV = S1L + l;
        pg_t [WIDTH-1:0] cur_s;
        pg_t [WIDTH-1:0] nxt_s;
        if (l == 0) begin : g_first
            assign cur_s = s1_pg_r;
        end else begin : g_rest
            assign cur_s = g_s2[l-1].nxt_s;
        end
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i < (1 << LV)) begin : g_pass
                assign nxt_s[i] = cur_s[i];
            end else begin : g_cell
                prefix_cell #(.GRAY((i < (2 << LV)) ? 1'b1 : 1'b0)) u_cell (
                    .hi (cur_s[i]),
                    .lo (cur_s[i - (1 << LV)]),
                    .o  (nxt_s[i])
                );
            end
        end
    end

    // Final carries C_i are the group generates; the group propagates are not needed past here.
    always_comb begin
        carry_s          = '0;
        final_p_unused_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            carry_s[i]          = g_s2[S2L-1].nxt_s[i].g;
            final_p_unused_s[i] = g_s2[S2L-1].nxt_s[i].p;
        end
    end

    // Sum bits of a + ~b + ~b_in; the borrow is the inverted final carry.
    always_comb begin
        diff_s    = '0;
        diff_s[0] = s1_p_r[0] ^ s1_cin_r;
        for (int i = 1; i < WIDTH; i++) begin
            diff_s[i] = s1_p_r[i] ^ carry_s[i-1];
        end
        b_out_s = ~carry_s[WIDTH-1];
    end

    // Stage 2 valid flag: a bubble from stage 1 is taken whenever stage 2 may advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
        end else if (s2_en_s) begin
            s2_valid_r <= s1_valid_r;
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    // Stage 2 result registers: held stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_r  <= '0;
            b_out_r <= 1'b0;
        end else if (s2_en_s && s1_valid_r) begin
            diff_r  <= diff_s;
            b_out_r <= b_out_s;
        end else begin
            diff_r  <= diff_r;
            b_out_r <= b_out_r;
        end
    end

    assign out_valid = s2_valid_r;
    assign diff      = diff_r;
    assign b_out     = b_out_r;

`ifdef PREFIX_SUB_FLAGS_EN
    logic       s1_a_msb_r;
    logic       s1_b_msb_r;
    logic [2:0] flags_s;
    logic [2:0] flags_r;

    // Operand sign bits travel with stage 1 for the overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a_msb_r <= 1'b0;
            s1_b_msb_r <= 1'b0;
        end else if (accept_s) begin
            s1_a_msb_r <= a[WIDTH-1];
            s1_b_msb_r <= b[WIDTH-1];
        end else begin
            s1_a_msb_r <= s1_a_msb_r;
            s1_b_msb_r <= s1_b_msb_r;
        end
    end

    // Signed overflow: operand signs differ and the result sign differs from the minuend's.
    always_comb begin
        flags_s         = 3'b000;
        flags_s[FLAG_N] = diff_s[WIDTH-1];
        flags_s[FLAG_Z] = (diff_s == '0);
        flags_s[FLAG_V] = (s1_a_msb_r ^ s1_b_msb_r) & (diff_s[WIDTH-1] ^ s1_a_msb_r);
    end

    // Flag register loads together with diff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r <= 3'b000;
        end else if (s2_en_s && s1_valid_r) begin
            flags_r <= flags_s;
        end else begin
            flags_r <= flags_r;
        end
    end

    assign flags = flags_r;
`endif

endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// Self-checking bench for prefix_subtractor_pipe (WIDTH=16) with a scoreboard queue of expected results.
// Flag checks are compiled in when PREFIX_SUB_FLAGS_EN is defined.
module tb_prefix_subtractor_pipe;

    typedef struct packed {
        logic [15:0] d;
        logic        bo;
        logic [2:0]  f;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        b_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        b_out;
`ifdef PREFIX_SUB_FLAGS_EN
    logic [2:0]  flags;
`endif

    int          errors;
    int          checks;
    exp_t        sb[$];
    logic        stall_r;
    logic [15:0] held_diff;
    logic        held_bout;

    prefix_subtractor_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .b_out     (b_out)
`ifdef PREFIX_SUB_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] aa, input logic [15:0] bb, input logic bi);
        exp_t        e;
        logic [16:0] r;
        r    = {1'b0, aa} - {1'b0, bb} - {16'd0, bi};
        e.d  = r[15:0];
        e.bo = r[16];
        e.f  = {r[15], (r[15:0] == 16'd0), (aa[15] ^ bb[15]) & (r[15] ^ aa[15])};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs after negedge, sample handshakes 1ns later, then advance to next negedge.
    task automatic do_cycle(input logic iv, input logic [15:0] aa, input logic [15:0] bb,
                            input logic bi, input logic ordy, output logic acc);
        exp_t e;
        in_valid  = iv;
        a         = aa;
        b         = bb;
        b_in      = bi;
        out_ready = ordy;
        #1;
        if (stall_r) begin
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_diff", {16'd0, diff}, {16'd0, held_diff});
            chk("stall_b_out", {31'd0, b_out}, {31'd0, held_bout});
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_output", sb.size(), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("diff", {16'd0, diff}, {16'd0, e.d});
                chk("b_out", {31'd0, b_out}, {31'd0, e.bo});
`ifdef PREFIX_SUB_FLAGS_EN
                chk("flags", {29'd0, flags}, {29'd0, e.f});
`endif
            end
        end
        acc = iv && in_ready;
        if (acc) sb.push_back(model(aa, bb, bi));
        stall_r   = out_valid && !out_ready;
        held_diff = diff;
        held_bout = b_out;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic        acc;
    int          ptr;
    int          n_acc;
    int          guard;
    logic [15:0] ta[3];
    logic [15:0] tb_[3];

    initial begin
        errors    = 0;
        checks    = 0;
        stall_r   = 1'b0;
        held_diff = 16'd0;
        held_bout = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 16'd0;
        b         = 16'd0;
        b_in      = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_diff", {16'd0, diff}, 32'd0);
        chk("rst_b_out", {31'd0, b_out}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: latency of exactly two clocks
        do_cycle(1'b1, 16'h1234, 16'h0234, 1'b0, 1'b1, acc);
        chk("t1_accept", {31'd0, acc}, 32'd1);
        chk("t1_lat_edge1", {31'd0, out_valid}, 32'd0);
        do_cycle(1'b0, 16'hDEAD, 16'hBEEF, 1'b1, 1'b1, acc);
        chk("t1_lat_edge2", {31'd0, out_valid}, 32'd1);
        chk("t1_diff_direct", {16'd0, diff}, 32'h1000);
        do_cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);

        // Tests 2/3: wrap-around, signed overflow, zero result
        do_cycle(1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1, acc);
        do_cycle(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, acc);
        do_cycle(1'b1, 16'h5555, 16'h5554, 1'b1, 1'b1, acc);
        do_cycle(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, acc);
        do_cycle(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, acc);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
        chk("t23_drained", sb.size(), 32'd0);

        // Test 4: backpressure for 5 cycles with 3 operations offered
        ta[0] = 16'h0100; tb_[0] = 16'h0001;
        ta[1] = 16'h0002; tb_[1] = 16'h0003;
        ta[2] = 16'h7FFF; tb_[2] = 16'hFFFF;
        ptr = 0;
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b1, ta[ptr], tb_[ptr], 1'b1, 1'b0, acc);
            if (acc) ptr++;
        end
        chk("t4_held_count", ptr, 32'd2);
        chk("t4_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("t4_out_valid_held", {31'd0, out_valid}, 32'd1);
        guard = 0;
        while (ptr < 3 && guard < 20) begin
            do_cycle(1'b1, ta[ptr], tb_[ptr], 1'b1, 1'b1, acc);
            if (acc) ptr++;
            guard++;
        end
        chk("t4_all_accepted", ptr, 32'd3);
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
        chk("t4_drained", sb.size(), 32'd0);

        // Test 5: asynchronous reset with two operations in flight
        do_cycle(1'b1, 16'h1111, 16'h0001, 1'b0, 1'b0, acc);
        do_cycle(1'b1, 16'h2222, 16'h0002, 1'b0, 1'b0, acc);
        chk("t5_pipe_full", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_async_diff", {16'd0, diff}, 32'd0);
        sb.delete();
        stall_r = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, 16'hAAAA, 16'h5555, 1'b1, 1'b1, acc);
            chk("t5_no_stale", {31'd0, out_valid}, 32'd0);
        end

        // Test 6: 1000 random operations with random in_valid/out_ready
        n_acc = 0;
        guard = 0;
        while (n_acc < 1000 && guard < 20000) begin
            do_cycle(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), acc);
            if (acc) n_acc++;
            guard++;
        end
        chk("t6_accepted", n_acc, 32'd1000);
        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            do_cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
            guard++;
        end
        chk("t6_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
